// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch sequencer states. S_FAULT is reachable only when the misaligned
  // target trap is built in.
  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_t;

  // addi x0,x0,0 -- presented to decode whenever no instruction is valid.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Byte distance between consecutive instruction words.
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Clears the two byte-offset bits so a loaded target is always word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one word request at a time
// over a valid/ready port, and holds the returned word for decode until it
// is retired. The next PC is chosen when decode accepts the instruction.
//
// Build option: define FETCH_MISALIGN_TRAP_EN to trap a taken target whose
// low two bits are non-zero (state S_FAULT, fetch_fault=1 until rst).
// Without it the target is silently word aligned and fetch_fault is 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory request / response
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // decode side
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  // control flow from the core
  input  logic        pc_source,
  input  logic [31:0] pc_target,
  output logic        fetch_fault
);

  import fetch_pkg::*;

  fetch_state_t state;
  fetch_state_t state_next;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] target_pc;
  logic [31:0] pc_next;
  logic        target_bad;
  logic        rsp_take;
  logic        accept;
  logic        req_valid_c;
  logic        instr_valid_c;

  // Sequential successor; 32-bit modulo so 0xFFFF_FFFC wraps to 0.
  assign pc_plus4 = pc + INSTR_BYTES;

`ifdef FETCH_MISALIGN_TRAP_EN
  // A taken, misaligned target is trapped and never loaded into the PC.
  assign target_bad = pc_source && (pc_target[1:0] != 2'b00);
  assign target_pc  = pc_target;
`else
  // Without the trap the byte-offset bits of a target are simply dropped.
  assign target_bad = 1'b0;
  assign target_pc  = align_word(pc_target);
`endif

  assign pc_next = pc_source ? target_pc : pc_plus4;

  // Handshake qualifiers: a response only counts while waiting for it, and
  // decode's ready only counts while an instruction is being held.
  assign rsp_take = (state == S_WAIT) && imem_rsp_valid;
  assign accept   = (state == S_HOLD) && instr_ready;

  // State register; reset wins over every handshake in the same cycle.
  always_ff @(posedge clk) begin
    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state handshake outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // through the case statement leaves one unassigned (which would infer a latch).
    state_next    = state;
    req_valid_c   = 1'b0;
    instr_valid_c = 1'b0;
    case (state)
      S_REQ: begin
        req_valid_c = 1'b1;
        if (imem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        instr_valid_c = 1'b1;
        if (instr_ready) begin
          state_next = target_bad ? S_FAULT : S_REQ;
        end
      end
      S_FAULT: begin
        // Parked until reset; no requests and nothing presented to decode.
        state_next = S_FAULT;
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Request is suppressed while reset is held so memory never sees a
  // request that the fetch stage would immediately abandon.
  assign imem_req_valid = req_valid_c && !rst;
  assign imem_addr      = pc;
  assign instr_valid    = instr_valid_c;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state == S_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  // PC and the instruction register presented to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc             <= RESET_PC;
      instr          <= NOP_INSTR;
      instr_pc       <= RESET_PC;
      instr_pc_plus4 <= RESET_PC + INSTR_BYTES;
    end else begin
      if (rsp_take) begin
        instr          <= imem_rsp_data;
        instr_pc       <= pc;
        instr_pc_plus4 <= pc_plus4;
      end
      if (accept) begin
        instr <= NOP_INSTR;
        if (!target_bad) begin
          pc <= pc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Stimulus pushes the expected request
// address and the expected decode-side tuple into queues; a monitor pops and
// compares whenever a request or an instruction handshake completes.
// Define FETCH_MISALIGN_TRAP_EN for both bench and RTL to cover the trap.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_source;
  logic [31:0] pc_target;
  logic        fetch_fault;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .pc_source      (pc_source),
    .pc_target      (pc_target),
    .fetch_fault    (fetch_fault)
  );

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        q_instr[$];
  logic [31:0] q_addr[$];

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int nvalid = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, where inputs and outputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (instr_valid) nvalid++;
      if (!rst && imem_req_valid && imem_req_ready) begin
        if (q_addr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL req_unexpected: got addr %h want no request", imem_addr);
        end else begin
          check("req_addr", imem_addr, q_addr.pop_front());
        end
      end
      if (!rst && instr_valid && instr_ready) begin
        if (q_instr.size() == 0) begin
          total++;
          bad++;
          $display("FAIL instr_unexpected: got instr %h want none", instr);
        end else begin
          e = q_instr.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, e.pc);
          check("instr_pc_plus4", instr_pc_plus4, e.pc4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and wait (bounded) for it to be taken.
  task automatic do_req(input logic [31:0] addr);
    int n;
    q_addr.push_back(addr);
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b1;
    n = 0;
    while (!imem_req_valid && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) begin
      total++;
      bad++;
      $display("FAIL req_wait: got no imem_req_valid want request at %h", addr);
    end
    tick();
    imem_req_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] data);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  // Retire the held instruction; control inputs are left at junk values
  // afterwards since they must only matter at the retire edge.
  task automatic do_accept(input logic src, input logic [31:0] tgt);
    instr_ready = 1'b1;
    pc_source   = src;
    pc_target   = tgt;
    tick();
    instr_ready = 1'b0;
    pc_source   = 1'b1;
    pc_target   = 32'hBAD0_0000;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                       input logic src, input logic [31:0] tgt);
    q_instr.push_back('{word: data, pc: addr, pc4: addr + 32'd4});
    do_req(addr);
    do_rsp(data);
    do_accept(src, tgt);
  endtask

  initial begin
    int c0;
    int v0;
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    pc_source      = 1'b0;
    pc_target      = 32'h0;
    repeat (3) tick();

    // Reset state
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, NOP);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_instr_pc_plus4", instr_pc_plus4, 32'h4);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    check("post_rst_addr", imem_addr, 32'h0);

    // Zero-wait memory, three sequential fetches: 3 cycles each, valid 1 in 3
    c0 = ncyc;
    v0 = nvalid;
    fetch(32'h0, NOP, 1'b0, 32'h0);
    fetch(32'h4, NOP, 1'b0, 32'h0);
    fetch(32'h8, NOP, 1'b0, 32'h0);
    check("seq_cycles", 32'(ncyc - c0), 32'd9);
    check("seq_valid_cycles", 32'(nvalid - v0), 32'd3);

    // Request stall at 0x10 with a spurious response during S_REQ
    fetch(32'hC, 32'h0010_0093, 1'b0, 32'h0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = JUNK;
    instr_ready    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_req_valid", 32'(imem_req_valid), 32'd1);
      check("stall_addr", imem_addr, 32'h10);
      check("stall_instr_valid", 32'(instr_valid), 32'd0);
      check("stall_instr", instr, NOP);
    end
    fetch(32'h10, 32'h0050_0093, 1'b0, 32'h0);
    fetch(32'h14, 32'h0000_0033, 1'b0, 32'h0);
    fetch(32'h18, 32'h0040_0113, 1'b0, 32'h0);
    fetch(32'h1C, 32'h0020_8233, 1'b0, 32'h0);

    // Held instruction at 0x20 with spurious responses, then a taken jump
    q_instr.push_back('{word: 32'h0080_006F, pc: 32'h20, pc4: 32'h24});
    do_req(32'h20);
    do_rsp(32'h0080_006F);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = JUNK;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_instr", instr, 32'h0080_006F);
      check("hold_instr_pc", instr_pc, 32'h20);
      check("hold_instr_valid", 32'(instr_valid), 32'd1);
    end
    imem_rsp_valid = 1'b0;
    do_accept(1'b1, 32'h100);

    // Misaligned taken target
`ifdef FETCH_MISALIGN_TRAP_EN
    fetch(32'h100, 32'h0020_0113, 1'b1, 32'h102);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fault_flag", 32'(fetch_fault), 32'd1);
      check("fault_req_valid", 32'(imem_req_valid), 32'd0);
      check("fault_instr_valid", 32'(instr_valid), 32'd0);
    end
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    fetch(32'h0, 32'h0000_0013, 1'b1, 32'hFFFF_FFFC);
`else
    fetch(32'h100, 32'h0020_0113, 1'b1, 32'h102);
    check("no_fault", 32'(fetch_fault), 32'd0);
    fetch(32'h100, 32'h0030_0193, 1'b1, 32'hFFFF_FFFC);
`endif

    // PC wrap at the top of the address space
    fetch(32'hFFFF_FFFC, 32'h0030_0193, 1'b0, 32'h0);
    fetch(32'h0, 32'h0070_0393, 1'b1, 32'h40);

    // Reset while waiting for a response; the late response is ignored
    do_req(32'h40);
    rst = 1'b1;
    tick();
    check("wait_rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("wait_rst_instr_valid", 32'(instr_valid), 32'd0);
    check("wait_rst_instr_pc", instr_pc, 32'h0);
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = JUNK;
    tick();
    imem_rsp_valid = 1'b0;
    check("late_rsp_instr_valid", 32'(instr_valid), 32'd0);
    check("late_rsp_instr", instr, NOP);
    check("late_rsp_req_valid", 32'(imem_req_valid), 32'd1);
    check("late_rsp_addr", imem_addr, 32'h0);
    tick();
    check("late_rsp_still_idle", 32'(instr_valid), 32'd0);
    fetch(32'h0, 32'h00A0_0513, 1'b0, 32'h0);

    tick();
    check("addr_queue_empty", 32'(q_addr.size()), 32'd0);
    check("instr_queue_empty", 32'(q_instr.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
